// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game state, level-scaled move tick, serve delay, scoring and winner.
// Optional pause feature is built only when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
  parameter int BASE_DIV    = 1000,
  parameter int DIV_STEP    = 100,
  parameter int MAX_LEVEL   = 7,
  parameter int SERVE_TICKS = 32,
  parameter int WIN_SCORE   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] sec1,
  input  logic       miss1,
  input  logic       miss2,
  output logic [1:0] state,
  output logic       move_tick,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] level
);

  typedef enum logic [1:0] {
    ST_NEW_GAME = 2'd0,
    ST_PLAY     = 2'd1,
    ST_NEW_BALL = 2'd2,
    ST_OVER     = 2'd3
  } state_t;

  localparam int CW = $clog2(BASE_DIV + 1);
  localparam int SW = $clog2(SERVE_TICKS + 1);

  state_t        state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n, period_s;
  logic [SW-1:0] serve_cnt_r, serve_cnt_n;
  logic [2:0]    level_r, level_n, level_in_s;
  logic [3:0]    score1_r, score1_n, score2_r, score2_n;
  logic [1:0]    winner_r, winner_n;
  logic          serve_dir_r, serve_dir_n;
  logic          tick_r, tick_n;
  logic          ball_reset_r, ball_reset_n;
  logic          start_q_r, start_rise_s, wrap_s, hold_s;

  function automatic logic [2:0] clamp_level(input logic [3:0] digit);
    if (digit > 4'(MAX_LEVEL)) begin
      clamp_level = 3'(MAX_LEVEL);
    end else begin
      clamp_level = digit[2:0];
    end
  endfunction

  assign start_rise_s = start & ~start_q_r;
  assign level_in_s   = clamp_level(sec1);
  assign period_s     = CW'(BASE_DIV - DIV_STEP * int'(level_r));
  assign wrap_s       = (cnt_r == period_s - CW'(1));

`ifdef PONG_PAUSE_EN
  logic pause_q_r, paused_r, pause_rise_s;

  assign pause_rise_s = pause & ~pause_q_r;
  // A pause edge freezes the divider in the same cycle, so the count resumes exactly where it stopped
  assign hold_s = (state_r == ST_PLAY) & (paused_r | pause_rise_s);

  // Pause flag toggles on pause edges in play and drops whenever play is left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_q_r <= 1'b0;
      paused_r  <= 1'b0;
    end else begin
      pause_q_r <= pause;
      if ((state_r != ST_PLAY) || (state_n != ST_PLAY)) begin
        paused_r <= 1'b0;
      end else if (pause_rise_s) begin
        paused_r <= ~paused_r;
      end else begin
        paused_r <= paused_r;
      end
    end
  end
`else
  logic unused_pause_s;

  assign unused_pause_s = pause;
  assign hold_s         = 1'b0;
`endif

  // Next-state, scoring and divider control
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    serve_cnt_n  = serve_cnt_r;
    level_n      = level_r;
    score1_n     = score1_r;
    score2_n     = score2_r;
    winner_n     = winner_r;
    serve_dir_n  = serve_dir_r;
    tick_n       = 1'b0;
    ball_reset_n = 1'b0;

    case (state_r)
      ST_NEW_GAME: begin
        if (start_rise_s) begin
          state_n = ST_NEW_BALL;
        end else begin
          state_n = ST_NEW_GAME;
        end
      end
      ST_NEW_BALL: begin
        // Exit one cycle after the last serve wrap has been counted
        if (serve_cnt_r == SW'(SERVE_TICKS)) begin
          state_n = ST_PLAY;
        end else begin
          state_n = ST_NEW_BALL;
        end
        if (wrap_s) begin
          serve_cnt_n = serve_cnt_r + SW'(1);
        end else begin
          serve_cnt_n = serve_cnt_r;
        end
      end
      ST_PLAY: begin
        if (hold_s) begin
          state_n = ST_PLAY;
        end else if (miss1 & miss2) begin
          state_n = ST_NEW_BALL;
        end else if (miss1) begin
          score2_n    = score2_r + 4'd1;
          serve_dir_n = 1'b0;
          if (score2_n == 4'(WIN_SCORE)) begin
            winner_n = 2'd2;
            state_n  = ST_OVER;
          end else begin
            state_n  = ST_NEW_BALL;
          end
        end else if (miss2) begin
          score1_n    = score1_r + 4'd1;
          serve_dir_n = 1'b1;
          if (score1_n == 4'(WIN_SCORE)) begin
            winner_n = 2'd1;
            state_n  = ST_OVER;
          end else begin
            state_n  = ST_NEW_BALL;
          end
        end else begin
          state_n = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_rise_s) begin
          state_n     = ST_NEW_GAME;
          score1_n    = 4'd0;
          score2_n    = 4'd0;
          winner_n    = 2'd0;
          serve_dir_n = 1'b0;
        end else begin
          state_n = ST_OVER;
        end
      end
      default: begin
        state_n = ST_NEW_GAME;
      end
    endcase

    if (state_n != state_r) begin
      cnt_n        = {CW{1'b0}};
      serve_cnt_n  = {SW{1'b0}};
      level_n      = level_in_s;
      ball_reset_n = (state_n == ST_NEW_BALL);
    end else if (hold_s) begin
      cnt_n = cnt_r;
    end else if (wrap_s) begin
      cnt_n   = {CW{1'b0}};
      level_n = level_in_s;
      tick_n  = (state_r == ST_PLAY);
    end else begin
      cnt_n = cnt_r + CW'(1);
    end
  end

  // State, divider, score and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_NEW_GAME;
      cnt_r        <= {CW{1'b0}};
      serve_cnt_r  <= {SW{1'b0}};
      level_r      <= 3'd0;
      score1_r     <= 4'd0;
      score2_r     <= 4'd0;
      winner_r     <= 2'd0;
      serve_dir_r  <= 1'b0;
      tick_r       <= 1'b0;
      ball_reset_r <= 1'b0;
      start_q_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      serve_cnt_r  <= serve_cnt_n;
      level_r      <= level_n;
      score1_r     <= score1_n;
      score2_r     <= score2_n;
      winner_r     <= winner_n;
      serve_dir_r  <= serve_dir_n;
      tick_r       <= tick_n;
      ball_reset_r <= ball_reset_n;
      start_q_r    <= start;
    end
  end

  assign state      = state_r;
  assign move_tick  = tick_r;
  assign ball_reset = ball_reset_r;
  assign serve_dir  = serve_dir_r;
  assign score1     = score1_r;
  assign score2     = score2_r;
  assign winner     = winner_r;
  assign level      = level_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed vector table, a cycle reference model
// driven by random stimulus, async reset and (with PONG_PAUSE_EN) the pause sequence.
module tb_pong_match_ctrl;

  localparam int BASE_DIV    = 20;
  localparam int DIV_STEP    = 2;
  localparam int MAX_LEVEL   = 7;
  localparam int SERVE_TICKS = 2;
  localparam int WIN_SCORE   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, miss1, miss2;
  logic [3:0] sec1;
  logic [1:0] state, winner;
  logic       move_tick, ball_reset, serve_dir;
  logic [3:0] score1, score2;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // reference model, written directly from the match rules
  int m_state, m_pos, m_level, m_wraps, m_s1, m_s2, m_win, m_dir;
  bit m_tick, m_br, m_start_prev;

  typedef struct {
    logic       start, miss1, miss2;
    logic [3:0] sec1;
    int         wait_n;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[$];

  pong_match_ctrl #(
    .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP), .MAX_LEVEL(MAX_LEVEL),
    .SERVE_TICKS(SERVE_TICKS), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .sec1(sec1),
    .miss1(miss1), .miss2(miss2), .state(state), .move_tick(move_tick),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score1(score1),
    .score2(score2), .winner(winner), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pack(input int st, tk, br, dir, s1, s2, win, lvl);
    return {2'(st), 1'(tk), 1'(br), 1'(dir), 4'(s1), 4'(s2), 2'(win), 3'(lvl)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {state, move_tick, ball_reset, serve_dir, score1, score2, winner, level};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_level = 0; m_wraps = 0;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
    m_tick = 1'b0; m_br = 1'b0; m_start_prev = 1'b0;
  endtask

  task automatic model_edge();
    int  period, nxt, lvl_in;
    bit  rise, wrap;
    rise         = start && !m_start_prev;
    m_start_prev = start;
    lvl_in       = (int'(sec1) > MAX_LEVEL) ? MAX_LEVEL : int'(sec1);
    period       = BASE_DIV - m_level * DIV_STEP;
    wrap         = (m_pos == period - 1);
    nxt          = m_state;
    case (m_state)
      0: if (rise) nxt = 2;
      2: if (m_wraps == SERVE_TICKS) nxt = 1;
      1: begin
        if (miss1 && miss2) nxt = 2;
        else if (miss1) begin
          m_s2++; m_dir = 0;
          if (m_s2 == WIN_SCORE) begin m_win = 2; nxt = 3; end else nxt = 2;
        end else if (miss2) begin
          m_s1++; m_dir = 1;
          if (m_s1 == WIN_SCORE) begin m_win = 1; nxt = 3; end else nxt = 2;
        end
      end
      3: if (rise) begin nxt = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; end
      default: nxt = 0;
    endcase
    m_tick = (m_state == 1) && (nxt == 1) && wrap;
    m_br   = (nxt == 2) && (m_state != 2);
    if (nxt != m_state) begin
      m_pos = 0; m_wraps = 0; m_level = lvl_in;
    end else if (wrap) begin
      m_pos = 0; m_wraps++; m_level = lvl_in;
    end else begin
      m_pos++;
    end
    m_state = nxt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (model_on) check("model_cycle", 32'(dut_vec()), 32'(pack(m_state, int'(m_tick), int'(m_br),
                        m_dir, m_s1, m_s2, m_win, m_level)));
  endtask

  task automatic row(input int s, m1, m2, sc, w, st, tk, br, dir, s1, s2, win, lvl);
    vec_t v;
    v.start = 1'(s); v.miss1 = 1'(m1); v.miss2 = 1'(m2); v.sec1 = 4'(sc); v.wait_n = w;
    v.exp = pack(st, tk, br, dir, s1, s2, win, lvl);
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int ticks;
    int r;
    rst = 1'b0; start = 1'b0; pause = 1'b0; miss1 = 1'b0; miss2 = 1'b0; sec1 = 4'd0;
    model_reset();

    //   st m1 m2 sec wait | state tick br dir s1 s2 win lvl
    row(1, 0, 0, 0, 1,    2, 0, 1, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 40,   2, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 1,    1, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 19,   1, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 1,    1, 1, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 1,    1, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 19,   1, 1, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 9, 19,   1, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 9, 1,    1, 1, 0, 0, 0, 0, 0, 7);
    row(0, 0, 0, 9, 5,    1, 0, 0, 0, 0, 0, 0, 7);
    row(0, 0, 0, 9, 1,    1, 1, 0, 0, 0, 0, 0, 7);
    row(0, 0, 0, 9, 6,    1, 1, 0, 0, 0, 0, 0, 7);
    row(0, 0, 1, 9, 1,    2, 0, 1, 1, 1, 0, 0, 7);
    row(0, 0, 0, 9, 12,   2, 0, 0, 1, 1, 0, 0, 7);
    row(0, 0, 0, 9, 1,    1, 0, 0, 1, 1, 0, 0, 7);
    row(0, 0, 1, 9, 1,    2, 0, 1, 1, 2, 0, 0, 7);
    row(0, 0, 0, 9, 13,   1, 0, 0, 1, 2, 0, 0, 7);
    row(0, 0, 1, 9, 1,    3, 0, 0, 1, 3, 0, 1, 7);
    row(0, 0, 0, 9, 30,   3, 0, 0, 1, 3, 0, 1, 7);
    row(1, 0, 0, 9, 2,    0, 0, 0, 0, 0, 0, 0, 7);
    row(1, 0, 0, 9, 1,    2, 0, 1, 0, 0, 0, 0, 7);
    row(0, 0, 0, 9, 13,   1, 0, 0, 0, 0, 0, 0, 7);
    row(0, 1, 0, 9, 1,    2, 0, 1, 0, 0, 1, 0, 7);
    row(0, 0, 1, 9, 1,    2, 0, 0, 0, 0, 1, 0, 7);
    row(0, 0, 0, 9, 12,   1, 0, 0, 0, 0, 1, 0, 7);
    row(0, 0, 1, 9, 1,    2, 0, 1, 1, 1, 1, 0, 7);
    row(0, 0, 0, 9, 13,   1, 0, 0, 1, 1, 1, 0, 7);
    row(0, 1, 1, 9, 1,    2, 0, 1, 1, 1, 1, 0, 7);
    row(0, 0, 0, 9, 13,   1, 0, 0, 1, 1, 1, 0, 7);
    row(1, 0, 0, 9, 2,    1, 0, 0, 1, 1, 1, 0, 7);
    row(0, 1, 0, 9, 1,    2, 0, 1, 0, 1, 2, 0, 7);
    row(0, 0, 0, 9, 13,   1, 0, 0, 0, 1, 2, 0, 7);
    row(0, 1, 0, 9, 1,    3, 0, 0, 0, 1, 3, 2, 7);
    row(0, 1, 0, 9, 1,    3, 0, 0, 0, 1, 3, 2, 7);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1'b1;
    model_on = 1'b1;

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; miss1 = tbl[i].miss1; miss2 = tbl[i].miss2; sec1 = tbl[i].sec1;
      cyc();
      start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
      for (int k = 1; k < tbl[i].wait_n; k++) cyc();
      check($sformatf("row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 49) == 0) sec1 = 4'($urandom_range(0, 15));
      miss1 = 1'b0; miss2 = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 3) miss1 = 1'b1;
      else if (r < 6) miss2 = 1'b1;
      else if (r < 7) begin miss1 = 1'b1; miss2 = 1'b1; end
      cyc();
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset", 32'(dut_vec()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0)));
    start = 1'b0; miss1 = 1'b0; miss2 = 1'b0; sec1 = 4'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check("post_reset_state", 32'(state), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("post_reset_start", 32'({state, ball_reset}), 32'({2'd2, 1'b1}));

`ifdef PONG_PAUSE_EN
    model_on = 1'b0;
    n = 0;
    while (state != 2'd1 && n < 200) begin cyc(); n++; end
    check("pause_enter_play", 32'(state), 32'd1);
    repeat (5) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    miss1 = 1'b1; cyc(); miss1 = 1'b0;
    check("pause_miss_ignored", 32'({state, score2}), 32'({2'd1, 4'd0}));
    ticks = 0;
    for (int k = 0; k < 100; k++) begin cyc(); if (move_tick) ticks++; end
    check("pause_no_ticks", 32'(ticks), 32'd0);
    pause = 1'b1; cyc(); pause = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!move_tick && n < 40);
    check("pause_resume_gap", 32'(n), 32'd15);
`else
    n = 0; ticks = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong game. It owns the game state (new_game / new_ball / play / over) and times the ball/paddle motion engine with a level-scaled move tick. It also inserts the serve delay, keeps both scores, and declares the winner. The motion engine only updates ball and paddle coordinates on `move_tick` and recentres the ball on `ball_reset`. It reports misses back to this block.

## Interface
- BASE_DIV, default 1000: clock cycles per move tick at level 0
- DIV_STEP, default 100: cycles removed from the tick period per level; BASE_DIV > MAX_LEVEL*DIV_STEP is required
- MAX_LEVEL, default 7: level saturation value
- SERVE_TICKS, default 32: tick periods of serve delay in new_ball
- WIN_SCORE, default 5: points that end the match (≤15)
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  player start button, level; only rising edges act
- pause  in  1  pause button, level; only rising edges act; used only with PONG_PAUSE_EN
- sec1  in  4  tens-of-seconds digit from the game timer
- miss1  in  1  one-cycle pulse: ball passed paddle1 (player2 scores)
- miss2  in  1  one-cycle pulse: ball passed paddle2 (player1 scores)
- state  out  2  0 new_game, 1 play, 2 new_ball, 3 over
- move_tick  out  1  one-cycle engine update strobe
- ball_reset  out  1  one-cycle pulse: recentre ball
- serve_dir  out  1  0 = serve toward paddle1, 1 = toward paddle2
- score1, score2  out  4 each  player scores
- winner  out  2  0 none, 1 player1, 2 player2
- level  out  3  current speed level

## Operation
- Start edge: `start_rise = start & ~start_q`, where `start_q` is registered `start`. `pause` is handled the same way.
- Tick divider `cnt` counts from 0 to PERIOD-1, where PERIOD = BASE_DIV − level*DIV_STEP. It is cleared on every state change.
- `level = min(sec1, MAX_LEVEL)`. It is resampled only when `cnt` wraps or when the state changes, so a period is never cut short.
- new_game:
  - Scores are 0, winner is 0, serve_dir is 0, and no ticks are issued.
  - `start_rise` moves to new_ball.
- new_ball:
  - `ball_reset` pulses in the first cycle of the state.
  - The divider runs, but `move_tick` stays low.
  - After SERVE_TICKS wraps, the block moves to play.
- play:
  - `move_tick` pulses on each divider wrap.
  - miss1: score2 increments and serve_dir becomes 0 (serve toward the conceding player).
  - miss2: score1 increments and serve_dir becomes 1.
  - If the new score equals WIN_SCORE, go to over and set winner. Otherwise go to new_ball.
- Simultaneous miss1 and miss2: no point is scored, serve_dir is unchanged, and the block goes to new_ball.
- Misses outside play are ignored. `start_rise` outside new_game and over is ignored.
- over:
  - Scores and winner hold, and no ticks are issued.
  - `start_rise` moves to new_game, which clears scores and winner on entry.

## Timing
- Reset values: state=0, move_tick=0, ball_reset=0, serve_dir=0, score1=0, score2=0, winner=0, level=0, cnt=0, start_q=0, pause_q=0.
- All outputs are registered.
- State changes one cycle after the qualifying input is sampled.
- `ball_reset` is high in the first cycle that state==2.
- The first cycle with state==play is cycle 0. The first `move_tick` is high in cycle PERIOD, and later ticks follow every PERIOD cycles.
- New_ball lasts SERVE_TICKS*PERIOD cycles, plus one transition cycle.
- Score and winner update in the same edge as the state change out of play.
- Reset asserted mid-operation clears everything immediately (asynchronous). After release the block is in new_game.

## Configuration
- PONG_PAUSE_EN defined:
  - In play, `pause_rise` freezes `cnt` and suppresses `move_tick` and misses.
  - The next `pause_rise` resumes from the frozen count.
  - Pause is cleared on leaving play and on reset.
- PONG_PAUSE_EN undefined: `pause` is ignored and no pause logic is built.

## Test plan
Parameters for all scenarios: BASE_DIV=20, DIV_STEP=2, MAX_LEVEL=7, SERVE_TICKS=2, WIN_SCORE=3.
- Reset release, then start pulse -> state=2 with one `ball_reset` pulse; state=1 after 41 cycles; `move_tick` every 20 cycles.
- In play, sec1=9 -> level saturates at 7 at the next wrap; `move_tick` spacing becomes 6 cycles.
- Three miss2 pulses, each in play -> score1=3, winner=1, state=3; `move_tick` stays low.
- miss1 and miss2 in the same cycle -> scores unchanged, state=2, serve_dir unchanged.
- In over, press start -> state=0 with scores 0; press start again -> new_ball.
- With PONG_PAUSE_EN: pause pulse at cnt=5 -> no ticks for 100 cycles; second pause pulse -> next tick arrives 15 cycles later.
